// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency memory between
//               instruction fetch (IF) and the data-memory stage (DM).
//               Each access takes the path IDLE -> BUSY -> DONE. The
//               requester that owns the access gets a one-cycle done pulse
//               in DONE, together with its registered read data.
//               stall_if holds the fetch stage while its request is open.
// Optional    : ARB_ROUND_ROBIN_EN - when both requests arrive together,
//               the requester that did not own the last completed access
//               wins the port. Without this macro, DM always wins a tie.
// Ports       : clk, reset              clock, synchronous active-high reset
//               if_req/if_addr          fetch request (level) and address
//               if_gnt/if_done/if_rdata fetch grant, done pulse, read data
//               dm_req/dm_we/dm_addr/   data request (level), write enable,
//               dm_wdata                address and write data
//               dm_gnt/dm_done/dm_rdata data grant, done pulse, read data
//               mem_en/mem_we/mem_addr/ memory strobe and latched command
//               mem_wdata/mem_rdata     signals, plus memory read data
//               stall_if                if_req & ~if_done
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       owner;
  logic [3:0] cnt;
  logic       grant;       // IDLE is accepting a request in this cycle
  logic       grant_dm;    // the request being accepted belongs to DM
  logic       tie_dm;      // DM wins if both requests are pending
  logic       busy_last;   // mem_rdata is valid in this cycle

  assign busy_last = (state == ST_BUSY) && (cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // This register changes when the read data is captured. It then holds the
  // owner of the last completed access before IDLE can see the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_IF;
    end else if (busy_last) begin
      last_owner <= owner;
    end
  end

  assign tie_dm = (last_owner == OWN_IF);
`else
  assign tie_dm = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Requests are sampled only in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_dm   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant      = 1'b1;
          next_state = ST_BUSY;
          grant_dm   = (if_req && dm_req) ? tie_dm : dm_req;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic for grants and done pulses
  // --------------------------------------------------------------------------
  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if_done = 1'b0;
    dm_done = 1'b0;
    if ((state == ST_BUSY) || (state == ST_DONE)) begin
      if_gnt = (owner == OWN_IF);
      dm_gnt = (owner == OWN_DM);
    end
    if (state == ST_DONE) begin
      if_done = (owner == OWN_IF);
      dm_done = (owner == OWN_DM);
    end
  end

  assign stall_if = if_req & ~if_done;

  // --------------------------------------------------------------------------
  // Datapath: the command is latched at grant, the latency count runs down,
  // and read data is captured in the last BUSY cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_IF;
      cnt       <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // grant is asserted only in IDLE, and IDLE lasts at least one cycle
      // after DONE. So this strobe can never be high in two cycles in a row.
      mem_en <= grant;

      if (grant) begin
        owner     <= grant_dm;
        cnt       <= LAT_INIT;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end else if ((state == ST_BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (busy_last) begin
        if (owner == OWN_DM) begin
          dm_rdata <= mem_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. It runs directed
//               and random request scenarios against a transaction-level
//               reference model and a behavioural fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [19:0] if_addr, dm_addr;
  logic [15:0] dm_wdata, mem_rdata;
  logic        if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, stall_if;
  logic [15:0] if_rdata, dm_rdata, mem_wdata;
  logic [19:0] mem_addr;

  // second instance with MEM_LAT = 1
  logic        l_if_req, l_dm_req, l_dm_we;
  logic [19:0] l_if_addr, l_dm_addr;
  logic [15:0] l_dm_wdata, l_mem_rdata;
  logic        l_if_gnt, l_if_done, l_dm_gnt, l_dm_done, l_mem_en, l_mem_we, l_stall_if;
  logic [15:0] l_if_rdata, l_dm_rdata, l_mem_wdata;
  logic [19:0] l_mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural memory (driven by the DUT's memory port) and reference copy
  logic [19:0] pool    [4];
  logic [15:0] mem     [4];
  logic [15:0] ref_mem [4];
  int          pend_c;
  logic [15:0] pend_d;
  logic [15:0] hold_if, hold_dm;
  bit          rr_last_dm;   // owner of the last completed access is DM

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .MEM_LAT(L)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt), .if_done(l_if_done),
    .if_rdata(l_if_rdata), .dm_req(l_dm_req), .dm_we(l_dm_we), .dm_addr(l_dm_addr),
    .dm_wdata(l_dm_wdata), .dm_gnt(l_dm_gnt), .dm_done(l_dm_done), .dm_rdata(l_dm_rdata),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata), .stall_if(l_stall_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_idx(input logic [19:0] a);
    for (int k = 0; k < 4; k++) if (pool[k] == a) return k;
    return -1;
  endfunction

  function automatic bit tie_goes_to_dm();
`ifdef ARB_ROUND_ROBIN_EN
    return !rr_last_dm;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_if_gnt"},    if_gnt,    0);
    check({tag, "_dm_gnt"},    dm_gnt,    0);
    check({tag, "_if_done"},   if_done,   0);
    check({tag, "_dm_done"},   dm_done,   0);
    check({tag, "_if_rdata"},  if_rdata,  0);
    check({tag, "_dm_rdata"},  dm_rdata,  0);
    check({tag, "_mem_en"},    mem_en,    0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_stall_if"},  stall_if,  0);
  endtask

  // One scenario: the requests are raised together in cycle 0 and each is
  // held until the cycle of its done pulse. The model sets the grant order
  // and the done cycles: the first owner is done in L+2, the second in 2L+5.
  task automatic run_scenario(input bit use_if, input bit use_dm, input bit we,
                              input int ii, input int di, input logic [15:0] wd);
    bit          first_dm;
    int          d_if, d_dm, last_c, idx;
    logic [15:0] exp_if, exp_dm;
    bit          e_if_gnt, e_dm_gnt, e_en;
    first_dm = (use_if && use_dm) ? tie_goes_to_dm() : use_dm;
    d_if = -1; d_dm = -1; exp_if = 16'h0; exp_dm = 16'h0;
    if (first_dm) begin
      d_dm = L + 2;
      exp_dm = we ? 16'h0 : ref_mem[di];
      if (we) ref_mem[di] = wd;
      if (use_if) begin d_if = 2*L + 5; exp_if = ref_mem[ii]; end
    end else if (use_if) begin
      d_if = L + 2;
      exp_if = ref_mem[ii];
      if (use_dm) begin
        d_dm = 2*L + 5;
        exp_dm = we ? 16'h0 : ref_mem[di];
        if (we) ref_mem[di] = wd;
      end
    end
    last_c = ((d_if > d_dm) ? d_if : d_dm);
    if (last_c < 1) last_c = 1;
    last_c = last_c + 1;
    pend_c = -1;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if_req   = (d_if >= 0) && (c <= d_if);
      dm_req   = (d_dm >= 0) && (c <= d_dm);
      if_addr  = if_req ? pool[ii] : 20'($urandom);
      dm_addr  = dm_req ? pool[di] : 20'($urandom);
      dm_we    = dm_req ? we : 1'($urandom);
      dm_wdata = dm_req ? wd : 16'($urandom);
      mem_rdata = (c == pend_c) ? pend_d : 16'($urandom);
      #1;
      e_if_gnt = (d_if >= 0) && (c >= d_if - L - 1) && (c <= d_if);
      e_dm_gnt = (d_dm >= 0) && (c >= d_dm - L - 1) && (c <= d_dm);
      e_en     = ((d_if >= 0) && (c == d_if - L - 1)) || ((d_dm >= 0) && (c == d_dm - L - 1));
      if (c == d_if) hold_if = exp_if;
      if (c == d_dm) hold_dm = exp_dm;
      check("if_gnt",   if_gnt,   e_if_gnt);
      check("dm_gnt",   dm_gnt,   e_dm_gnt);
      check("if_done",  if_done,  (d_if >= 0) && (c == d_if));
      check("dm_done",  dm_done,  (d_dm >= 0) && (c == d_dm));
      check("stall_if", stall_if, (d_if >= 0) && (c < d_if));
      check("mem_en",   mem_en,   e_en);
      check("if_rdata", if_rdata, hold_if);
      check("dm_rdata", dm_rdata, hold_dm);
      if (mem_en) begin
        idx = find_idx(mem_addr);
        check("mem_addr_known", idx >= 0, 1);
        if ((d_if >= 0) && (c == d_if - L - 1)) begin
          check("if_mem_addr", mem_addr, pool[ii]);
          check("if_mem_we",   mem_we,   0);
        end
        if ((d_dm >= 0) && (c == d_dm - L - 1)) begin
          check("dm_mem_addr", mem_addr, pool[di]);
          check("dm_mem_we",   mem_we,   we);
          if (we) check("dm_mem_wdata", mem_wdata, wd);
        end
        if (idx >= 0) begin
          if (mem_we) mem[idx] = mem_wdata;
          else begin pend_c = c + L; pend_d = mem[idx]; end
        end
      end
    end
    if (use_if && use_dm) rr_last_dm = !first_dm;
    else if (use_if || use_dm) rr_last_dm = use_dm;
  endtask

  // DM read interrupted by a reset sampled at the end of cycle 2.
  task automatic reset_scenario();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      reset     = (c == 2);
      dm_req    = (c <= 2);
      dm_we     = 1'b0;
      dm_addr   = pool[2];
      if_req    = 1'b0;
      mem_rdata = 16'($urandom);
      #1;
      if (c == 1) check("rst_mid_mem_en", mem_en, 1);
      if (c == 2) check("rst_mid_dm_gnt", dm_gnt, 1);
      if (c >= 3) check_zero("rst_mid");
    end
    hold_if = 16'h0; hold_dm = 16'h0; rr_last_dm = 1'b0; pend_c = -1;
  endtask

  task automatic lat1_test();
    int en_count = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      l_if_req    = (c <= 3);
      l_if_addr   = 20'h00ABC;
      l_mem_rdata = (c == 2) ? 16'hA5A5 : 16'($urandom);
      #1;
      if (l_mem_en) en_count++;
      check("lat1_mem_en",   l_mem_en,   c == 1);
      check("lat1_if_done",  l_if_done,  c == 3);
      check("lat1_stall_if", l_stall_if, c < 3);
      if (c == 1) check("lat1_mem_addr", l_mem_addr, 20'h00ABC);
      if (c >= 3) check("lat1_if_rdata", l_if_rdata, 16'hA5A5);
    end
    check("lat1_en_count", en_count, 1);
  endtask

  initial begin
    bit          r_if, r_dm, r_we;
    int          r_ii, r_di;
    logic [15:0] r_wd;
    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    l_if_req = 0; l_dm_req = 0; l_dm_we = 0; l_if_addr = 0; l_dm_addr = 0; l_dm_wdata = 0;
    l_mem_rdata = 0;
    pool[0] = 20'h00010;
    pool[1] = 20'h00200;
    pool[2] = {16'($urandom), 4'h2};
    pool[3] = {16'($urandom), 4'h3};
    for (int k = 0; k < 4; k++) begin
      mem[k] = 16'($urandom);
      ref_mem[k] = mem[k];
    end
    mem[0] = 16'hBEEF; ref_mem[0] = 16'hBEEF;
    hold_if = 0; hold_dm = 0; rr_last_dm = 0; pend_c = -1; pend_d = 0;

    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    run_scenario(1, 0, 0, 0, 0, 16'h0);      // fetch read of 0x00010 -> 0xBEEF
    run_scenario(0, 1, 1, 0, 1, 16'h1234);   // DM write to 0x00200
    run_scenario(1, 1, 0, 2, 1, 16'h0);      // tie: DM read then IF
    run_scenario(1, 1, 1, 3, 2, 16'h5A5A);   // three back-to-back ties
    run_scenario(1, 1, 0, 1, 3, 16'h0);
    run_scenario(1, 1, 1, 2, 2, 16'hC3C3);

    reset_scenario();

    for (int n = 0; n < 40; n++) begin
      r_if = 1'($urandom);
      r_dm = 1'($urandom);
      r_we = 1'($urandom);
      r_ii = $urandom_range(0, 3);
      r_di = $urandom_range(0, 3);
      r_wd = 16'($urandom);
      run_scenario(r_if, r_dm, r_we, r_ii, r_di, r_wd);
    end

    lat1_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port memory between instruction fetch (IF) and the data-memory stage (DM), for example load, store, push and pop.
- Sequences each access through a fixed-latency memory.
- Returns read data with a one-cycle done pulse.
- Drives a fetch-stall signal to the pipeline control so IF holds while DM owns the port.

Parameters:
ADDR_W, 20, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; level, held until if_done
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch owns the port
if_done  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched word
dm_req  in  1  data request; level, held until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data stage owns the port
dm_done  out  1  one-cycle completion pulse
dm_rdata  out  DATA_W  read data; 0 after a write
mem_en  out  1  one-cycle access strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  latched access address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  combinational: if_req & ~if_done

Behaviour:
- States: IDLE, BUSY, DONE. A 1-bit owner register holds 0 = IF, 1 = DM. A 4-bit counter cnt tracks latency.
- Reset values: state IDLE, owner IF, cnt 0. All outputs 0, including registered rdata values and the mem_* outputs.
- IDLE, neither request pending: stay in IDLE.
- IDLE, only one request pending: grant that requester.
- IDLE, both requests pending: grant DM (fixed priority, unless the optional feature is enabled).
- On grant (IDLE -> BUSY):
  - latch addr, we and wdata into the mem_* outputs;
  - set owner;
  - cnt <= MEM_LAT;
  - mem_en is high for the first BUSY cycle only;
  - mem_we equals dm_we for DM and is 0 for IF.
- BUSY:
  - cnt decrements each cycle;
  - when cnt == 0, register mem_rdata into the owner's rdata (0 for DM writes) and go to DONE.
- DONE:
  - the owner's done is high for exactly one cycle;
  - next state is always IDLE.
- Requester protocol: the requester drops req in the cycle after it sees done. Because IDLE samples req one cycle after DONE, there is no spurious re-grant.
- Grant and latency timing:
  - if_gnt / dm_gnt are high throughout BUSY and DONE for the owner only;
  - latency from the cycle req is first sampled in IDLE to the done cycle is MEM_LAT + 2;
  - minimum spacing between two grants is MEM_LAT + 3 cycles.
- Request inputs are ignored outside IDLE. Address and data changes during BUSY have no effect because they are latched at grant.
- The non-owner's rdata holds its previous value.
- stall_if is high while if_req is pending and not being completed. This includes the entire time DM owns the port.
- Reset asserted mid-access:
  - the next cycle is IDLE with all outputs cleared;
  - the in-flight access is abandoned and its done pulse is never produced;
  - memory side effects already issued are not undone.
- mem_en is never high in two consecutive cycles.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined:
  - a last_owner register (reset value IF) records the owner of the most recent completed grant;
  - on a simultaneous request, the requester that is not last_owner wins;
  - single requests are unaffected.
- When undefined: DM always wins ties, and no last_owner logic exists.

Test Plan:
- Fetch read: if_req = 1, if_addr = 0x00010, mem_rdata = 0xBEEF, MEM_LAT = 2 -> mem_en in cycle 1 with mem_addr = 0x00010; if_done and if_rdata = 0xBEEF in cycle 4; stall_if high in cycles 0-3.
- DM write: dm_req = 1, dm_we = 1, dm_addr = 0x00200, dm_wdata = 0x1234 -> one mem_en with mem_we = 1 and mem_wdata = 0x1234; dm_done in cycle 4 with dm_rdata = 0.
- Simultaneous requests, feature off: if_req and dm_req both asserted in cycle 0:
  - DM is granted and completes in cycle 4;
  - IF is granted in cycle 5 and if_done arrives in cycle 9;
  - stall_if stays high through cycle 8.
- Simultaneous requests, feature on, repeated: three back-to-back tied pairs -> grant order DM, IF, DM, IF, DM, IF.
- Reset in cycle 2 of a DM read -> cycle 3 is IDLE; dm_done never pulses; all outputs are 0.
- MEM_LAT = 1, single IF read -> if_done in cycle 3; mem_en is high for exactly one cycle.
